// File: rtl/counter_sequencer.sv
// Pass sequencer with an embedded WIDTH-bit counter: up/down, modulo wrap, repeat, bounce, pause, abort.
// Latency: start accepted at edge N -> LOAD, Q = start_val after N+1, first step at N+2; done is a 1-cycle pulse.
// Backpressure: pause freezes Q/pass_cnt via HOLD; abort returns to IDLE with no done; start is ignored outside IDLE.
// Optional feature macro: COUNTER_SEQ_CYCLES_EN adds run_cycles[7:0] (saturating count of unpaused RUN cycles).
module counter_sequencer #(
  parameter int WIDTH  = 3,
  parameter int REPS_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  end_val,
  input  logic              dir,
  input  logic              bounce,
  input  logic [REPS_W-1:0] reps,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  Q,
  output logic              busy,
  output logic              done,
  output logic              tc,
  output logic [REPS_W-1:0] pass_cnt
`ifdef COUNTER_SEQ_CYCLES_EN
  ,
  output logic [7:0]        run_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    q_q;
  logic [WIDTH-1:0]    target_q;
  logic                cur_dir_q;
  logic [REPS_W-1:0]   pass_cnt_q;
  logic                busy_q;
  logic                done_q;

  // Configuration captured on an accepted start.
  logic [WIDTH-1:0]    start_val_q;
  logic [WIDTH-1:0]    end_val_q;
  logic                dir_q;
  logic                bounce_q;
  logic [REPS_W-1:0]   reps_q;

  logic [WIDTH-1:0]    q_step_d;
  logic                at_target;

  // Next counter value for a normal step; arithmetic wraps naturally at WIDTH bits.
  always_comb begin
    q_step_d  = cur_dir_q ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
    at_target = (q_q == target_q);
    tc        = (state_q == S_RUN) && at_target && !pause && !abort;
  end

  // Sequencer FSM; counter, pass count and busy/done are all registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      target_q    <= '0;
      cur_dir_q   <= 1'b0;
      pass_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_val_q <= '0;
      end_val_q   <= '0;
      dir_q       <= 1'b0;
      bounce_q    <= 1'b0;
      reps_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_val_q <= start_val;
            end_val_q   <= end_val;
            dir_q       <= dir;
            bounce_q    <= bounce;
            reps_q      <= reps;
            pass_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            q_q       <= start_val_q;
            target_q  <= end_val_q;
            cur_dir_q <= dir_q;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (pause) begin
            state_q <= S_HOLD;
          end else if (at_target) begin
            if (pass_cnt_q == reps_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pass_cnt_q <= pass_cnt_q + REPS_W'(1);
              if (bounce_q) begin
                // Q dwells one cycle at the turnaround, then heads back.
                target_q  <= (target_q == end_val_q) ? start_val_q : end_val_q;
                cur_dir_q <= ~cur_dir_q;
              end else begin
                q_q <= start_val_q;
              end
            end
          end else begin
            q_q <= q_step_d;
          end
        end
        S_HOLD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!pause) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Q        = q_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_cnt_q;

`ifdef COUNTER_SEQ_CYCLES_EN
  logic [7:0] run_cycles_q;

  // Counts RUN cycles that actually advance the sequence; paused cycles are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      run_cycles_q <= '0;
    end else if ((state_q == S_RUN) && !pause && (run_cycles_q != 8'hFF)) begin
      run_cycles_q <= run_cycles_q + 8'd1;
    end
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed runs with hand-computed per-cycle expectations.
// Stimulus pushes expected (Q, tc, busy, done, pass_cnt) records; a negedge monitor pops one per busy/done cycle.
// Idle-state results (reset, abort, ignored start) are checked directly by the stimulus.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] start_val;
  logic [2:0] end_val;
  logic       dir;
  logic       bounce;
  logic [2:0] reps;
  logic       pause;
  logic       abort;
  logic [2:0] Q;
  logic       busy;
  logic       done;
  logic       tc;
  logic [2:0] pass_cnt;
`ifdef COUNTER_SEQ_CYCLES_EN
  logic [7:0] run_cycles;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] q;
    logic       tc;
    logic       busy;
    logic       done;
    logic [2:0] pc;
  } exp_t;

  exp_t exp_q[$];

  counter_sequencer #(.WIDTH(3), .REPS_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_val (start_val),
    .end_val   (end_val),
    .dir       (dir),
    .bounce    (bounce),
    .reps      (reps),
    .pause     (pause),
    .abort     (abort),
    .Q         (Q),
    .busy      (busy),
    .done      (done),
    .tc        (tc),
    .pass_cnt  (pass_cnt)
`ifdef COUNTER_SEQ_CYCLES_EN
    ,
    .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int q, input int t, input int b, input int d, input int pc);
    exp_t e;
    e.q    = 3'(q);
    e.tc   = 1'(t);
    e.busy = 1'(b);
    e.done = 1'(d);
    e.pc   = 3'(pc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sv, input int ev, input int d, input int bn, input int rp);
    start_val = 3'(sv);
    end_val   = 3'(ev);
    dir       = 1'(d);
    bounce    = 1'(bn);
    reps      = 3'(rp);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 60) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (n < 60) ? 1 : 0, 1);
    tick();
  endtask

  // Monitor: every cycle the DUT shows activity, compare against the next expected record.
  always @(negedge clk) begin
    if (busy || done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: Q=%0d busy=%0d done=%0d with no expectation at %0t",
                 Q, busy, done, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("Q", int'(Q), int'(e.q));
        check("tc", int'(tc), int'(e.tc));
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
        check("pass_cnt", int'(pass_cnt), int'(e.pc));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_val = '0; end_val = '0; dir = 1'b0;
    bounce = 1'b0; reps = '0; pause = 1'b0; abort = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_Q", int'(Q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass_cnt", int'(pass_cnt), 0);
    check("rst_tc", int'(tc), 0);
`ifdef COUNTER_SEQ_CYCLES_EN
    check("rst_run_cycles", int'(run_cycles), 0);
`endif

    // Basic up run 2 -> 5, single pass.
    push(0,0,1,0,0); push(2,0,1,0,0); push(3,0,1,0,0); push(4,0,1,0,0);
    push(5,1,1,0,0); push(5,0,0,1,0);
    do_start(2, 5, 0, 0, 0);
    drain("up_run");
    check("up_busy_after", int'(busy), 0);
`ifdef COUNTER_SEQ_CYCLES_EN
    check("up_run_cycles", int'(run_cycles), 4);
`endif

    // Down run with wrap, two passes, restart from start_val.
    push(5,0,1,0,0);
    push(1,0,1,0,0); push(0,0,1,0,0); push(7,0,1,0,0); push(6,1,1,0,0);
    push(1,0,1,0,1); push(0,0,1,0,1); push(7,0,1,0,1); push(6,1,1,0,1);
    push(6,0,0,1,1);
    do_start(1, 6, 1, 0, 1);
    drain("down_wrap");
    check("down_pass_cnt_idle", int'(pass_cnt), 1);

    // Bounce 1 <-> 3, three passes with a dwell at each turnaround.
    push(6,0,1,0,0);
    push(1,0,1,0,0); push(2,0,1,0,0); push(3,1,1,0,0);
    push(3,0,1,0,1); push(2,0,1,0,1); push(1,1,1,0,1);
    push(1,0,1,0,2); push(2,0,1,0,2); push(3,1,1,0,2);
    push(3,0,0,1,2);
    do_start(1, 3, 0, 1, 2);
    drain("bounce");
    check("bounce_pass_cnt_idle", int'(pass_cnt), 2);

    // Pause at Q=4 for three cycles, resume, then abort at Q=6.
    push(3,0,1,0,0);
    push(0,0,1,0,0); push(1,0,1,0,0); push(2,0,1,0,0); push(3,0,1,0,0);
    push(4,0,1,0,0); push(4,0,1,0,0); push(4,0,1,0,0); push(4,0,1,0,0); push(4,0,1,0,0);
    push(5,0,1,0,0); push(6,0,1,0,0);
    do_start(0, 7, 0, 0, 0);            // now in LOAD
    repeat (5) tick();                  // RUN with Q=4
    pause = 1'b1;
    tick(); tick();
    check("hold_busy", int'(busy), 1);
    tick();
    pause = 1'b0;
    tick(); tick(); tick();             // RUN with Q=6
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_Q", int'(Q), 6);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    drain("abort");

    // Start pulses during RUN and DONE must be ignored.
    push(6,0,1,0,0); push(2,0,1,0,0); push(3,0,1,0,0); push(4,0,1,0,0);
    push(5,1,1,0,0); push(5,0,0,1,0);
    do_start(2, 5, 0, 0, 0);            // LOAD
    tick();                             // Q=2
    tick();                             // Q=3
    start = 1'b1; start_val = 3'd0; end_val = 3'd7; reps = 3'd3;
    tick();
    start = 1'b0;
    tick();                             // Q=5, tc
    tick();                             // DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_busy_1", int'(busy), 0);
    tick();
    check("ign_start_busy_2", int'(busy), 0);
    check("ign_start_Q", int'(Q), 5);
    drain("ign_start");

    // 2 -> 5 with three paused cycles at Q=3: same RUN-cycle count as unpaused.
    push(5,0,1,0,0); push(2,0,1,0,0);
    push(3,0,1,0,0); push(3,0,1,0,0); push(3,0,1,0,0); push(3,0,1,0,0); push(3,0,1,0,0);
    push(4,0,1,0,0); push(5,1,1,0,0); push(5,0,0,1,0);
    do_start(2, 5, 0, 0, 0);
    tick(); tick();                     // RUN Q=3
    pause = 1'b1;
    tick(); tick(); tick();
    pause = 1'b0;
    drain("pause_run");
`ifdef COUNTER_SEQ_CYCLES_EN
    check("pause_run_cycles", int'(run_cycles), 4);
`endif

    // Reset mid-run: everything clears at the next edge with no done pulse.
    push(5,0,1,0,0); push(0,0,1,0,0); push(1,0,1,0,0); push(2,0,1,0,0);
    do_start(0, 7, 0, 0, 1);
    tick(); tick(); tick();             // RUN Q=2
    reset = 1'b1;
    tick();
    check("midrst_Q", int'(Q), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_pass_cnt", int'(pass_cnt), 0);
    reset = 1'b0;
    tick();
    check("midrst_done_after", int'(done), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
